// File: rtl/mem_port_arbiter.sv
// Round-robin owner of a shared XLEN-wide memory port for 4 requesters.
// Sequences request -> accept -> response, aborting a response wait after RSP_TIMEOUT cycles.
module mem_port_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int RSP_TIMEOUT = 64,
  parameter int CNT_W       = 7
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [NUM_REQ-1:0] rsp_valid_o,
  output logic [NUM_REQ-1:0] err_o,
  output logic [1:0]         sel_o,
  output logic               bus_valid_o,
  input  logic               bus_ready_i,
  input  logic               bus_rsp_valid_i,
  output logic               busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT_RSP} state_t;

  state_t             state_q, state_d;
  logic [1:0]         sel_q, sel_d;
  logic [1:0]         last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [NUM_REQ-1:0] rsp_q, rsp_d;
  logic [NUM_REQ-1:0] err_q, err_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;

  logic               pick_vld;
  logic [1:0]         pick_idx;
  logic [1:0]         scan_idx;

  // Scan starts one past the last owner so the previous owner has lowest priority.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = 2'd0;
    scan_idx = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      scan_idx = last_q + 2'(k);
      if (!pick_vld && req_i[scan_idx]) begin
        pick_vld = 1'b1;
        pick_idx = scan_idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    gnt_d   = '0;
    rsp_d   = '0;
    err_d   = '0;
    valid_d = valid_q;
    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          state_d = S_REQ;
          sel_d   = pick_idx;
          valid_d = 1'b1;
        end
      end
      S_REQ: begin
        if (valid_q && bus_ready_i) begin
          gnt_d[sel_q] = 1'b1;
          valid_d      = 1'b0;
          cnt_d        = '0;
          state_d      = S_WAIT_RSP;
        end
      end
      S_WAIT_RSP: begin
        cnt_d = cnt_q + 1'b1;
        // A response arriving on the timeout cycle still counts as a response.
        if (bus_rsp_valid_i) begin
          rsp_d[sel_q] = 1'b1;
          last_d       = sel_q;
          state_d      = S_IDLE;
        end else if (cnt_q == CNT_W'(RSP_TIMEOUT - 1)) begin
          err_d[sel_q] = 1'b1;
          last_d       = sel_q;
          state_d      = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        valid_d = 1'b0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sel_q   <= 2'd0;
      last_q  <= 2'd3;
      cnt_q   <= '0;
      gnt_q   <= '0;
      rsp_q   <= '0;
      err_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      rsp_q   <= rsp_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign rsp_valid_o = rsp_q;
  assign err_o       = err_q;
  assign sel_o       = sel_q;
  assign bus_valid_o = valid_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, hand-written corner sequences,
// then random traffic compared against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int TO = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'd0;
  logic       rdy = 1'b0;
  logic       rsp = 1'b0;
  logic [3:0] gnt_o, rsp_valid_o, err_o;
  logic [1:0] sel_o;
  logic       bus_valid_o, busy_o;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.NUM_REQ(4), .RSP_TIMEOUT(TO), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .req_i(req), .gnt_o(gnt_o), .rsp_valid_o(rsp_valid_o),
    .err_o(err_o), .sel_o(sel_o), .bus_valid_o(bus_valid_o), .bus_ready_i(rdy),
    .bus_rsp_valid_i(rsp), .busy_o(busy_o)
  );

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       rdy, rsp;
    logic [3:0] gnt, rv, err;
    logic [1:0] sel;
    logic       vld, busy;
  } vec_t;

  vec_t tbl[$];

  // Reference model: who owns the port, whether the downstream accepted, and when.
  bit         m_busy, m_granted;
  int         m_owner, m_last, m_gcyc, m_cyc;
  logic [3:0] e_gnt, e_rv, e_err;

  task automatic model_eval();
    e_gnt = '0; e_rv = '0; e_err = '0;
    if (rst) begin
      m_busy = 0; m_granted = 0; m_owner = 0; m_last = 3;
    end else if (!m_busy) begin
      for (int k = 1; k <= 4; k++) begin
        int c;
        c = (m_last + k) % 4;
        if (req[c]) begin
          m_owner = c; m_busy = 1; m_granted = 0;
          break;
        end
      end
    end else if (!m_granted) begin
      if (rdy) begin
        e_gnt[m_owner] = 1'b1; m_granted = 1; m_gcyc = m_cyc;
      end
    end else if (rsp) begin
      e_rv[m_owner] = 1'b1; m_last = m_owner; m_busy = 0;
    end else if (m_cyc - m_gcyc >= TO) begin
      e_err[m_owner] = 1'b1; m_last = m_owner; m_busy = 0;
    end
    m_cyc++;
  endtask

  task automatic step();
    model_eval();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic [3:0] q, input logic y, input logic s);
    rst = r; req = q; rdy = y; rsp = s;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic expect_out(input string nm, input logic [3:0] g, input logic [3:0] v,
                            input logic [3:0] e, input logic [1:0] s, input logic bv,
                            input logic b);
    chk({nm, ".gnt"}, 32'(gnt_o), 32'(g));
    chk({nm, ".rsp"}, 32'(rsp_valid_o), 32'(v));
    chk({nm, ".err"}, 32'(err_o), 32'(e));
    chk({nm, ".sel"}, 32'(sel_o), 32'(s));
    chk({nm, ".vld"}, 32'(bus_valid_o), 32'(bv));
    chk({nm, ".busy"}, 32'(busy_o), 32'(b));
  endtask

  task automatic add(input logic r, input logic [3:0] q, input logic y, input logic s,
                     input logic [3:0] g, input logic [3:0] v, input logic [3:0] e,
                     input logic [1:0] sl, input logic bv, input logic b);
    vec_t t;
    t.rst = r; t.req = q; t.rdy = y; t.rsp = s;
    t.gnt = g; t.rv = v; t.err = e; t.sel = sl; t.vld = bv; t.busy = b;
    tbl.push_back(t);
  endtask

  initial begin
    int order[5];
    order = '{0, 1, 2, 3, 0};

    // Single requester, response two cycles after accept.
    add(1, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 4'b0001, 1, 0, 0, 0, 0, 0, 1, 1);
    add(0, 4'b0001, 1, 0, 4'b0001, 0, 0, 0, 0, 1);
    add(0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 1);
    add(0, 4'b0000, 0, 1, 0, 4'b0001, 0, 0, 0, 0);
    add(0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0);
    // All four held with immediate response; stray rsp outside the wait is ignored.
    add(1, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0);
    foreach (order[i]) begin
      add(0, 4'hF, 1, 1, 0, 0, 0, 2'(order[i]), 1, 1);
      add(0, 4'hF, 1, 1, 4'(1 << order[i]), 0, 0, 2'(order[i]), 0, 1);
      add(0, 4'hF, 1, 1, 0, 4'(1 << order[i]), 0, 2'(order[i]), 0, 0);
    end
    // After serving 2, {0,2} requesting: pointer wraps to 0.
    add(1, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 4'b0100, 1, 0, 0, 0, 0, 2, 1, 1);
    add(0, 4'b0100, 1, 0, 4'b0100, 0, 0, 2, 0, 1);
    add(0, 4'b0000, 0, 1, 0, 4'b0100, 0, 2, 0, 0);
    add(0, 4'b0101, 1, 0, 0, 0, 0, 0, 1, 1);
    add(0, 4'b0101, 1, 0, 4'b0001, 0, 0, 0, 0, 1);
    add(0, 4'b0100, 0, 1, 0, 4'b0001, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].req, tbl[i].rdy, tbl[i].rsp);
      step();
      expect_out($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].rv, tbl[i].err,
                 tbl[i].sel, tbl[i].vld, tbl[i].busy);
    end

    // Ready stall: valid and select hold while the port refuses.
    drive(1, 4'b0000, 0, 0); step();
    drive(0, 4'b0010, 0, 0); step();
    expect_out("stall_start", 0, 0, 0, 1, 1, 1);
    for (int i = 0; i < 10; i++) begin
      step();
      expect_out($sformatf("stall%0d", i), 0, 0, 0, 1, 1, 1);
    end
    drive(0, 4'b0010, 1, 0); step();
    expect_out("stall_gnt", 4'b0010, 0, 0, 1, 0, 1);
    drive(0, 4'b0000, 0, 1); step();
    expect_out("stall_rsp", 0, 4'b0010, 0, 1, 0, 0);

    // Timeout: err exactly TO cycles after the grant pulse.
    drive(0, 4'b0010, 1, 0); step();
    expect_out("to_req", 0, 0, 0, 1, 1, 1);
    step();
    expect_out("to_gnt", 4'b0010, 0, 0, 1, 0, 1);
    drive(0, 4'b0000, 0, 0);
    for (int i = 0; i < TO - 1; i++) begin
      step();
      expect_out($sformatf("to_wait%0d", i), 0, 0, 0, 1, 0, 1);
    end
    step();
    expect_out("to_err", 0, 0, 4'b0010, 1, 0, 0);

    // Response on the final timeout cycle wins over the error.
    drive(0, 4'b0010, 1, 0); step();
    step();
    expect_out("late_gnt", 4'b0010, 0, 0, 1, 0, 1);
    drive(0, 4'b0000, 0, 0);
    for (int i = 0; i < TO - 1; i++) step();
    drive(0, 4'b0000, 0, 1); step();
    expect_out("late_rsp", 0, 4'b0010, 0, 1, 0, 0);
    drive(0, 4'b0000, 0, 0); step();
    expect_out("late_after", 0, 0, 0, 1, 0, 0);

    // Reset while waiting for a response drops the transaction silently.
    drive(0, 4'b0100, 1, 0); step();
    expect_out("rst_req", 0, 0, 0, 2, 1, 1);
    step();
    expect_out("rst_gnt", 4'b0100, 0, 0, 2, 0, 1);
    drive(1, 4'b0000, 0, 0); step();
    expect_out("rst_clear", 0, 0, 0, 0, 0, 0);
    drive(0, 4'b0000, 0, 1); step();
    expect_out("rst_stale_rsp", 0, 0, 0, 0, 0, 0);
    drive(0, 4'b1000, 1, 0); step();
    expect_out("rst_next_req", 0, 0, 0, 3, 1, 1);
    step();
    expect_out("rst_next_gnt", 4'b1000, 0, 0, 3, 0, 1);
    drive(0, 4'b0000, 0, 1); step();
    expect_out("rst_next_rsp", 0, 4'b1000, 0, 3, 0, 0);

    // Random traffic against the reference model.
    drive(1, 4'b0000, 0, 0); step();
    for (int c = 0; c < 4000; c++) begin
      logic [3:0] nreq;
      nreq = req;
      for (int i = 0; i < 4; i++) begin
        if (gnt_o[i]) nreq[i] = 1'b0;
        else if (!nreq[i] && ($urandom_range(3) == 0)) nreq[i] = 1'b1;
      end
      drive(($urandom_range(299) == 0), nreq, 1'($urandom_range(1)),
            ($urandom_range(9) < 3));
      step();
      expect_out($sformatf("rnd%0d", c), e_gnt, e_rv, e_err, 2'(m_owner),
                 m_busy && !m_granted, m_busy);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
